// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall hold, flush bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [31:0]      RSdata_i,
   input  logic [31:0]      RTdata_i,
   input  logic [31:0]      imm_i,
   input  logic [4:0]       RSaddr_i,
   input  logic [4:0]       RTaddr_i,
   input  logic [4:0]       RDaddr_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic             ALUSrc_i,
   input  logic             RegDst_i,
   input  logic [1:0]       ALUOp_i,
   output logic [31:0]      RSdata_o,
   output logic [31:0]      RTdata_o,
   output logic [31:0]      imm_o,
   output logic [4:0]       RSaddr_o,
   output logic [4:0]       RTaddr_o,
   output logic [4:0]       RDaddr_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             ALUSrc_o,
   output logic             RegDst_o,
   output logic [1:0]       ALUOp_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);
   typedef struct packed {
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  rd_addr;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        alu_src;
      logic        reg_dst;
      logic [1:0]  alu_op;
      logic        valid;
   } stage_t;

   stage_t           id_s, stage_d, stage_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign id_s = {RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i,
                  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i,
                  RegDst_i, ALUOp_i, 1'b1};

   // A bubble is the all-zero word, so it never looks like a register producer.
   always_comb begin
      stage_d = flush_i ? '0 : stall_i ? stage_q : id_s;
      cnt_d   = (flush_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   assign RSdata_o     = stage_q.rs_data;
   assign RTdata_o     = stage_q.rt_data;
   assign imm_o        = stage_q.imm;
   assign RSaddr_o     = stage_q.rs_addr;
   assign RTaddr_o     = stage_q.rt_addr;
   assign RDaddr_o     = stage_q.rd_addr;
   assign RegWrite_o   = stage_q.reg_write;
   assign MemtoReg_o   = stage_q.mem_to_reg;
   assign MemRead_o    = stage_q.mem_read;
   assign MemWrite_o   = stage_q.mem_write;
   assign ALUSrc_o     = stage_q.alu_src;
   assign RegDst_o     = stage_q.reg_dst;
   assign ALUOp_o      = stage_q.alu_op;
   assign valid_o      = stage_q.valid;
   assign bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed bench for id_ex_reg (default and 4-bit counter),
// with a cycle-by-cycle reference model plus hand-computed spot checks.
module tb_id_ex_reg;
   logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] rs_d = '0, rt_d = '0, imm = '0;
   logic [4:0]  rs_a = '0, rt_a = '0, rd_a = '0;
   logic [5:0]  ctl = '0;
   logic [1:0]  aluop = '0;
   logic [119:0] o16, o4, exp_v;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;
   int          e16 = 0, e4 = 0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .RSdata_i(rs_d), .RTdata_i(rt_d), .imm_i(imm),
      .RSaddr_i(rs_a), .RTaddr_i(rt_a), .RDaddr_i(rd_a),
      .RegWrite_i(ctl[5]), .MemtoReg_i(ctl[4]), .MemRead_i(ctl[3]),
      .MemWrite_i(ctl[2]), .ALUSrc_i(ctl[1]), .RegDst_i(ctl[0]), .ALUOp_i(aluop),
      .RSdata_o(o16[119:88]), .RTdata_o(o16[87:56]), .imm_o(o16[55:24]),
      .RSaddr_o(o16[23:19]), .RTaddr_o(o16[18:14]), .RDaddr_o(o16[13:9]),
      .RegWrite_o(o16[8]), .MemtoReg_o(o16[7]), .MemRead_o(o16[6]),
      .MemWrite_o(o16[5]), .ALUSrc_o(o16[4]), .RegDst_o(o16[3]),
      .ALUOp_o(o16[2:1]), .valid_o(o16[0]), .bubble_cnt_o(cnt16)
   );

   id_ex_reg #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .RSdata_i(rs_d), .RTdata_i(rt_d), .imm_i(imm),
      .RSaddr_i(rs_a), .RTaddr_i(rt_a), .RDaddr_i(rd_a),
      .RegWrite_i(ctl[5]), .MemtoReg_i(ctl[4]), .MemRead_i(ctl[3]),
      .MemWrite_i(ctl[2]), .ALUSrc_i(ctl[1]), .RegDst_i(ctl[0]), .ALUOp_i(aluop),
      .RSdata_o(o4[119:88]), .RTdata_o(o4[87:56]), .imm_o(o4[55:24]),
      .RSaddr_o(o4[23:19]), .RTaddr_o(o4[18:14]), .RDaddr_o(o4[13:9]),
      .RegWrite_o(o4[8]), .MemtoReg_o(o4[7]), .MemRead_o(o4[6]),
      .MemWrite_o(o4[5]), .ALUSrc_o(o4[4]), .RegDst_o(o4[3]),
      .ALUOp_o(o4[2:1]), .valid_o(o4[0]), .bubble_cnt_o(cnt4)
   );

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Reference: the stage shows the ID word of the last non-stalled edge, or
   // zero after a flush; the counters count flush edges and clamp at their max.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_v <= '0;
         e16   <= 0;
         e4    <= 0;
      end else if (flush) begin
         exp_v <= '0;
         e16   <= (e16 < 65535) ? e16 + 1 : 65535;
         e4    <= (e4 < 15) ? e4 + 1 : 15;
      end else if (!stall) begin
         exp_v <= {rs_d, rt_d, imm, rs_a, rt_a, rd_a, ctl, aluop, 1'b1};
      end
   end

   always @(negedge clk) begin
      check("stage16", o16, exp_v);
      check("stage4", o4, exp_v);
      check("cnt16", cnt16, e16);
      check("cnt4", cnt4, e4);
   end

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [31:0] a, b, c, input logic [4:0] x, y, z,
                         input logic [5:0] k, input logic [1:0] op);
      rs_d = a; rt_d = b; imm = c; rs_a = x; rt_a = y; rd_a = z; ctl = k; aluop = op;
   endtask

   initial begin
      #12;
      check("reset_valid", o16[0], 1'b0);
      check("reset_cnt", cnt16, 16'd0);
      rst = 1'b1;
      // load: RegWrite + ALUSrc, rd=8
      set_in(32'h5, 32'h0, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd8, 6'b100010, 2'b00);
      edge_();
      check("load_rs", o16[119:88], 32'h5);
      check("load_imm", o16[55:24], 32'hFFFF_FFFC);
      check("load_alusrc", o16[4], 1'b1);
      check("load_regwrite", o16[8], 1'b1);
      check("load_rd", o16[13:9], 5'd8);
      check("load_valid", o16[0], 1'b1);
      stall = 1'b1;
      rs_d = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         edge_();
         check("stall_rs", o16[119:88], 32'h5);
         check("stall_rd", o16[13:9], 5'd8);
      end
      stall = 1'b0;
      edge_();
      check("release_rs", o16[119:88], 32'h1234);
      stall = 1'b1; flush = 1'b1; ctl = 6'b000100;
      edge_();
      check("fs_memwrite", o16[5], 1'b0);
      check("fs_regwrite", o16[8], 1'b0);
      check("fs_valid", o16[0], 1'b0);
      check("fs_cnt", cnt16, 16'd1);
      stall = 1'b0;
      rs_d = 'x; ctl = 6'b111111;
      edge_();
      check("flush_x_rs", o16[119:88], 32'h0);
      check("flush_x_ctl", o16[8:3], 6'h0);
      for (int i = 0; i < 20; i++) edge_();
      check("sat_cnt4", cnt4, 4'd15);
      check("cnt16_22", cnt16, 16'd22);
      flush = 1'b0;
      set_in(32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd3, 6'b101001, 2'b10);
      edge_();
      check("load_cnt_hold", cnt16, 16'd22);
      check("load_aluop", o16[2:1], 2'b10);
      // bring counter to 3 with a live instruction, then reset between edges
      rst = 1'b0; #1; rst = 1'b1;
      flush = 1'b1;
      for (int i = 0; i < 3; i++) edge_();
      flush = 1'b0;
      edge_();
      check("pre_rst_cnt", cnt16, 16'd3);
      check("pre_rst_valid", o16[0], 1'b1);
      #2 rst = 1'b0;
      #1;
      check("async_out", o16, 120'd0);
      check("async_cnt", cnt16, 16'd0);
      flush = 1'b1;
      edge_();
      edge_();
      check("rst_hold_cnt", cnt16, 16'd0);
      check("rst_hold_valid", o16[0], 1'b0);
      flush = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         set_in($urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                6'($urandom), 2'($urandom));
         edge_();
         check("b2b_rs", o16[119:88], rs_d);
         check("b2b_rd", o16[13:9], rd_a);
      end
      stall = 1'b1;
      for (int i = 0; i < 10; i++) edge_();
      check("long_stall_rs", o16[119:88], rs_d);
      stall = 1'b0;
      edge_();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
